// File: rtl/uart_tx_scheduler.sv
// Purpose : round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latency : byte on tx_data and send strobe low on the cycle after the accept edge; next grant HOLD_CYCLES+1 cycles later.
// Backpress: req_ready (combinational, one-hot) only in IDLE with tx_enable=1; requesters hold valid/data until accepted.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   tx_enable          1 = new grants allowed; 0 = finish current byte, grant nothing further
//   req_valid/req_data per-requester byte offer; requester i owns req_data[8i+7:8i]
//   req_ready          one-hot accept toward the winning requester
//   tx_data/tx_send_n  registered drive of the uart dataOut / sendOnLow inputs
//   grant_id           index of the last accepted requester
//   busy               high whenever the scheduler is not in IDLE
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int SEND_PULSE  = 4,
    parameter int HOLD_CYCLES = 264491,
    parameter int CNT_W       = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_send_n,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        RECOVER = 2'd0,
        IDLE    = 2'd1,
        SEND    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        tx_data_nxt;
    logic              tx_send_n_nxt;
    logic [ID_W-1:0]   grant_id_nxt;

    logic              found;
    logic [ID_W-1:0]   sel;
    logic [7:0]        sel_byte;
    logic              grant_ok;
    logic              accept;

    // Round-robin search: first pass covers indices above the last grant,
    // second pass wraps to the indices at or below it.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i > int'(grant_id)) && req_valid[i]) begin
                found    = 1'b1;
                sel      = ID_W'(i);
                sel_byte = req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i <= int'(grant_id)) && req_valid[i]) begin
                found    = 1'b1;
                sel      = ID_W'(i);
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    // State resets asynchronously to RECOVER, so ready is forced low
    // for the whole time rst_n is asserted.
    assign grant_ok = (state == IDLE) && tx_enable && found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_ok && (sel == ID_W'(i));
        end
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RECOVER;
            cnt       <= '0;
            tx_data   <= '0;
            tx_send_n <= 1'b1;
            grant_id  <= ID_W'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tx_data   <= tx_data_nxt;
            tx_send_n <= tx_send_n_nxt;
            grant_id  <= grant_id_nxt;
        end
    end

    // The counter runs continuously from the accept edge through SEND and
    // HOLD, so the HOLD exit compare measures the whole accept-to-IDLE span.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tx_data_nxt   = tx_data;
        tx_send_n_nxt = tx_send_n;
        grant_id_nxt  = grant_id;
        case (state)
            RECOVER: begin
                // The uart has no reset: let any frame/debounce in flight drain.
                if (cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE: begin
                if (accept) begin
                    tx_data_nxt   = sel_byte;
                    grant_id_nxt  = sel;
                    tx_send_n_nxt = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == SEND_LAST) begin
                    tx_send_n_nxt = 1'b1;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = RECOVER;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose : directed self-checking bench for uart_tx_scheduler with a small uart receiver model.
// Latency : checks accept-to-strobe of one cycle and accept spacing of HOLD_CYCLES+1.
// Backpress: requesters hold valid until the bench sees the grant, then update valid.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int SEND_PULSE  = 2;
    localparam int HOLD_CYCLES = 20;
    localparam int CNT_W       = 24;
    localparam int UART_BUSY   = 18;

    logic        clk;
    logic        rst_n;
    logic        tx_enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_send_n;
    logic [1:0]  grant_id;
    logic        busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_acc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uart_tx_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .SEND_PULSE (SEND_PULSE),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_enable(tx_enable),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_send_n(tx_send_n),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the IDLE cycle where the grant is expected; returns on the
    // cycle right after the accept edge.
    task automatic grant_step(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                              input logic [7:0] exp_byte, input logic [3:0] valid_after, input bit gap);
        chk({tag, "_ready"}, req_ready, exp_rdy);
        @(negedge clk);
        chk({tag, "_tx_data"}, tx_data, exp_byte);
        chk({tag, "_grant_id"}, grant_id, exp_id);
        chk({tag, "_send_low"}, tx_send_n, 1'b0);
        chk({tag, "_ready_off"}, req_ready, 4'b0000);
        chk({tag, "_busy"}, busy, 1'b1);
        if (gap) chk({tag, "_spacing"}, cyc - last_acc, HOLD_CYCLES + 1);
        last_acc = cyc;
        exp_q.push_back(exp_byte);
        req_valid = valid_after;
    endtask

    // Counts busy and strobe-low cycles until IDLE is reached (bounded).
    task automatic finish_byte(input string tag, input int exp_busy, input int exp_low);
        int b = 0;
        int l = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            b++;
            if (tx_send_n === 1'b0) l++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, b, exp_busy);
        chk({tag, "_low_cycles"}, l, exp_low);
    endtask

    // Uart receiver model: latches the byte on the strobe's falling edge and
    // stays busy for a frame-plus-debounce window.
    initial begin
        int  mbusy  = 0;
        logic prev_n = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_n === 1'b1 && tx_send_n === 1'b0) begin
                chk("uart_idle_at_strobe", mbusy, 0);
                rx_q.push_back(tx_data);
                mbusy = UART_BUSY;
            end else if (mbusy != 0) begin
                mbusy--;
            end
            prev_n = tx_send_n;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of run, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] va;
        rst_n     = 1'b0;
        tx_enable = 1'b1;
        req_valid = 4'b0001;
        req_data  = 32'h13121141;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_send_n", tx_send_n, 1'b1);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant_id", grant_id, 2'd3);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", req_ready, 4'b0000);

        // Release: RECOVER for HOLD_CYCLES cycles, no ready
        rst_n = 1'b1;
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            chk("recover_ready", req_ready, 4'b0000);
            @(negedge clk);
        end
        chk("first_idle_busy", busy, 1'b0);
        grant_step("t1", 4'b0001, 2'd0, 8'h41, 4'b0000, 1'b0);
        finish_byte("t1", HOLD_CYCLES, SEND_PULSE);

        // No requests in IDLE: nothing moves
        for (int i = 0; i < 3; i++) begin
            chk("quiet_busy", busy, 1'b0);
            chk("quiet_ready", req_ready, 4'b0000);
            chk("quiet_tx_data", tx_data, 8'h41);
            chk("quiet_grant_id", grant_id, 2'd0);
            chk("quiet_send_n", tx_send_n, 1'b1);
            @(negedge clk);
        end

        // Single request from 3 puts the pointer at 3, then all four compete
        req_data  = 32'h13121110;
        req_valid = 4'b1000;
        #1;
        grant_step("fill", 4'b1000, 2'd3, 8'h13, 4'b1111, 1'b0);
        finish_byte("fill", HOLD_CYCLES, SEND_PULSE);

        for (int i = 0; i < 5; i++) begin
            logic [1:0] id;
            logic [3:0] oh;
            id = 2'(i % 4);
            oh = 4'b0001 << id;
            va = (i == 4) ? 4'b0100 : 4'b1111;
            grant_step("t2", oh, id, 8'h10 + 8'(id), va, 1'b1);
            finish_byte("t2", HOLD_CYCLES, SEND_PULSE);
        end

        // Pointer at 2 with only 1 and 3 valid: 3 first, then wrap to 1
        grant_step("t3a", 4'b0100, 2'd2, 8'h12, 4'b1010, 1'b1);
        finish_byte("t3a", HOLD_CYCLES, SEND_PULSE);
        grant_step("t3b", 4'b1000, 2'd3, 8'h13, 4'b1010, 1'b1);
        finish_byte("t3b", HOLD_CYCLES, SEND_PULSE);
        grant_step("t3c", 4'b0010, 2'd1, 8'h11, 4'b0001, 1'b1);

        // tx_enable drops at HOLD cnt=5: byte runs to completion, no new grant
        repeat (5) @(negedge clk);
        tx_enable = 1'b0;
        finish_byte("t4", HOLD_CYCLES - 5, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_disabled_ready", req_ready, 4'b0000);
            chk("t4_disabled_busy", busy, 1'b0);
            chk("t4_disabled_tx_data", tx_data, 8'h11);
            @(negedge clk);
        end
        tx_enable = 1'b1;
        #1;
        grant_step("t4g", 4'b0001, 2'd0, 8'h10, 4'b0000, 1'b0);

        // Reset at HOLD cnt=8: outputs return immediately, full RECOVER follows
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_send_n", tx_send_n, 1'b1);
        chk("t5_rst_tx_data", tx_data, 8'h00);
        chk("t5_rst_grant_id", grant_id, 2'd3);
        chk("t5_rst_busy", busy, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("t5_rst_ready", req_ready, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            chk("t5_recover_ready", req_ready, 4'b0000);
            @(negedge clk);
        end
        grant_step("t5", 4'b0100, 2'd2, 8'h12, 4'b0000, 1'b0);
        finish_byte("t5", HOLD_CYCLES, SEND_PULSE);

        // Uart model got exactly the accepted bytes, in order
        repeat (2) @(negedge clk);
        chk("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp_q[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
